// File: rtl/wb_delay_mem.sv
// Wishbone slave memory with a fixed response latency.
// A decoded request is latched in IDLE. The slave then waits DELAYS edges and
// acknowledges for one cycle. Storage is 2^AW 32-bit words with byte enables.
// Handshake: a request is taken when cyc, stb and an address hit are sampled
// together in IDLE. ack is a one-cycle pulse. rdata is non-zero only during
// an ack for a read. Dropping cyc before the ack abandons the transfer.
module wb_delay_mem #(
  parameter int          DELAYS    = 10,
  parameter logic [31:0] ADDR_BASE = 32'h3800_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFC0_0000,
  parameter int          AW        = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // The counter reaches this value on the edge before the ack edge.
  localparam logic [7:0] LAST = 8'(DELAYS - 1);

  state_t        state;
  logic [7:0]    cnt;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   dat_q;
  logic [31:0]   mem [2**AW];

  logic          hit;
  logic [AW-1:0] idx;
  logic          commit;

  // Address decode. Byte offset bits are dropped. High bits alias into storage.
  always_comb begin
    hit = ((wbs_adr_i & ADDR_MASK) == ADDR_BASE);
    idx = wbs_adr_i[AW+1:2];
  end

  // The WAIT->ACK edge. An abort (cyc low) on the same edge wins.
  always_comb begin
    commit = (state == ST_WAIT) && wbs_cyc_i && (cnt == LAST);
  end

  // Transfer FSM: latches the request, counts the delay, and drives ack/rdata/busy.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 8'd0;
      we_q      <= 1'b0;
      sel_q     <= 4'd0;
      idx_q     <= '0;
      dat_q     <= 32'd0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
      busy_o    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= 32'd0;
          if (wbs_cyc_i && wbs_stb_i && hit) begin
            we_q   <= wbs_we_i;
            sel_q  <= wbs_sel_i;
            idx_q  <= idx;
            dat_q  <= wbs_dat_i;
            cnt    <= 8'd0;
            busy_o <= 1'b1;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!wbs_cyc_i) begin
            cnt    <= 8'd0;
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end else if (cnt == LAST) begin
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= we_q ? 32'd0 : mem[idx_q];
            state     <= ST_ACK;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_ACK: begin
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= 32'd0;
          busy_o    <= 1'b0;
          cnt       <= 8'd0;
          state     <= ST_IDLE;
        end
        default: begin
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= 32'd0;
          busy_o    <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Storage write on the ack edge. Only enabled bytes change. Storage is never reset.
  always_ff @(posedge wb_clk_i) begin
    if (commit && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) mem[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_delay_mem.sv
// Directed bench for wb_delay_mem.
// Unit 0 uses DELAYS=10 and unit 1 uses DELAYS=1. Both units share the clock and reset.
module tb_wb_delay_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc  [2];
  logic        stb  [2];
  logic        we   [2];
  logic [3:0]  sel  [2];
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        ack  [2];
  logic        busy [2];

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  wb_delay_mem #(.DELAYS(10)) dut0 (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]), .wbs_sel_i(sel[0]),
    .wbs_adr_i(adr[0]), .wbs_dat_i(wdat[0]),
    .wbs_ack_o(ack[0]), .wbs_dat_o(rdat[0]), .busy_o(busy[0])
  );

  wb_delay_mem #(.DELAYS(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]), .wbs_sel_i(sel[1]),
    .wbs_adr_i(adr[1]), .wbs_dat_i(wdat[1]),
    .wbs_ack_o(ack[1]), .wbs_dat_o(rdat[1]), .busy_o(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle(input int u);
    cyc[u] = 1'b0; stb[u] = 1'b0; we[u] = 1'b0;
    sel[u] = 4'h0; adr[u] = 32'h0; wdat[u] = 32'h0;
  endtask

  // One transfer. Edge 0 is the first posedge after the request is driven.
  // After edge 0 the bus is scrambled (cyc held) because the DUT must use latched values.
  task automatic xfer(input int u, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input int exp_edge, output logic [31:0] rd);
    int ack_edge = -1;
    int busy_cnt = 0;
    logic bad_dat = 1'b0;
    rd = 32'hxxxx_xxxx;
    @(negedge clk);
    cyc[u] = 1'b1; stb[u] = 1'b1; we[u] = w; adr[u] = a; wdat[u] = d; sel[u] = s;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy[u]) busy_cnt++;
      if (k == 0) begin
        adr[u] = $urandom; wdat[u] = $urandom;
        sel[u] = 4'($urandom_range(0, 15)); we[u] = ~w; stb[u] = 1'($urandom_range(0, 1));
      end
      if (ack[u]) begin
        ack_edge = k;
        rd = rdat[u];
        break;
      end else if (rdat[u] !== 32'h0) begin
        bad_dat = 1'b1;
      end
    end
    bus_idle(u);
    check("ack_edge", 32'(ack_edge), 32'(exp_edge));
    check("busy_edges", 32'(busy_cnt), 32'(exp_edge + 1));
    check("dat_zero_no_ack", {31'd0, bad_dat}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("ack_one_cycle", {31'd0, ack[u]}, 32'd0);
    check("busy_after_ack", {31'd0, busy[u]}, 32'd0);
    check("dat_after_ack", rdat[u], 32'd0);
  endtask

  logic [31:0] rd;
  int          hits;
  logic [5:0]  ack_pat;

  initial begin
    bus_idle(0);
    bus_idle(1);
    #2;
    check("rst_ack", {31'd0, ack[0]}, 32'd0);
    check("rst_busy", {31'd0, busy[0]}, 32'd0);
    check("rst_dat", rdat[0], 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write and read-back with DELAYS=10.
    xfer(0, 1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 10, rd);
    check("wr_dat_o_zero", rd, 32'h0);
    xfer(0, 1'b0, 32'h3800_0010, 32'h0, 4'hF, 10, rd);
    check("rd_deadbeef", rd, 32'hDEAD_BEEF);

    // Aliasing above the word index, and ignored byte-offset bits.
    xfer(0, 1'b0, 32'h3800_0413, 32'h0, 4'hF, 10, rd);
    check("rd_alias", rd, 32'hDEAD_BEEF);

    // Byte-enable merge.
    xfer(0, 1'b1, 32'h3800_0020, 32'h1122_3344, 4'hF, 10, rd);
    xfer(0, 1'b1, 32'h3800_0020, 32'hAABB_CCDD, 4'b0101, 10, rd);
    xfer(0, 1'b0, 32'h3800_0020, 32'h0, 4'hF, 10, rd);
    check("rd_sel_merge", rd, 32'h11BB_33DD);

    // A miss must not respond or touch storage. Index 0 is preloaded.
    xfer(0, 1'b1, 32'h3800_0000, 32'h55AA_0FF0, 4'hF, 10, rd);
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h3000_0000;
    wdat[0] = 32'hFFFF_FFFF; sel[0] = 4'hF;
    hits = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack[0] || busy[0]) hits++;
    end
    bus_idle(0);
    check("miss_no_resp", 32'(hits), 32'd0);
    xfer(0, 1'b0, 32'h3800_0000, 32'h0, 4'hF, 10, rd);
    check("miss_storage", rd, 32'h55AA_0FF0);

    // Abort: cyc drops after edge 5. IDLE is expected after edge 6.
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h3800_0010;
    wdat[0] = 32'h1234_5678; sel[0] = 4'hF;
    hits = 0;
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack[0]) hits++;
    end
    check("abort_busy_pre", {31'd0, busy[0]}, 32'd1);
    cyc[0] = 1'b0;
    stb[0] = 1'b0;
    for (int k = 6; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 6) check("abort_idle_e6", {31'd0, busy[0]}, 32'd0);
      if (ack[0]) hits++;
    end
    bus_idle(0);
    check("abort_no_ack", 32'(hits), 32'd0);
    xfer(0, 1'b0, 32'h3800_0010, 32'h0, 4'hF, 10, rd);
    check("abort_old_val", rd, 32'hDEAD_BEEF);

    // Reset pulse at edge 4 of a write.
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h3800_0010;
    wdat[0] = 32'hCAFE_F00D; sel[0] = 4'hF;
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk);
    end
    #1;
    check("rst_busy_pre", {31'd0, busy[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy[0]}, 32'd0);
    check("arst_ack", {31'd0, ack[0]}, 32'd0);
    check("arst_dat", rdat[0], 32'd0);
    @(negedge clk);
    bus_idle(0);
    rst_n = 1'b1;
    xfer(0, 1'b0, 32'h3800_0010, 32'h0, 4'hF, 10, rd);
    check("rst_no_commit", rd, 32'hDEAD_BEEF);

    // Back-to-back reads on the DELAYS=1 unit with stb held.
    xfer(1, 1'b1, 32'h3800_0000, 32'hA5A5_0001, 4'hF, 1, rd);
    xfer(1, 1'b1, 32'h3800_0004, 32'h5A5A_0002, 4'hF, 1, rd);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF; adr[1] = 32'h3800_0000;
    ack_pat = 6'd0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      ack_pat[k] = ack[1];
      if (k == 1) begin
        check("b2b_rd0", rdat[1], 32'hA5A5_0001);
        adr[1] = 32'h3800_0004;
      end
      if (k == 4) begin
        check("b2b_rd1", rdat[1], 32'h5A5A_0002);
        bus_idle(1);
      end
    end
    check("b2b_ack_pattern", {26'd0, ack_pat}, 32'b010010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_delay_mem.md
WB_DELAY_MEM -- requirements
Module: wb_delay_mem

Interface
REQ-001 Parameter DELAYS, default 10, SHALL set wait cycles between request acceptance and ack; legal range 1..255.
REQ-002 Parameter ADDR_BASE, default 32'h3800_0000, SHALL be the decode base address.
REQ-003 Parameter ADDR_MASK, default 32'hFFC0_0000, SHALL be the decode mask.
REQ-004 Parameter AW, default 8, SHALL set word-address width; storage depth 2^AW x 32 bits.
REQ-005 wb_clk_i  input  1  sole clock; all state on rising edge.
REQ-006 wb_rst_n  input  1  asynchronous active-low reset.
REQ-007 wbs_cyc_i  input  1  Wishbone cycle.
REQ-008 wbs_stb_i  input  1  Wishbone strobe.
REQ-009 wbs_we_i  input  1  1 = write, 0 = read.
REQ-010 wbs_sel_i  input  4  byte enables; bit n covers dat[8n+7:8n].
REQ-011 wbs_adr_i  input  32  byte address.
REQ-012 wbs_dat_i  input  32  write data.
REQ-013 wbs_ack_o  output  1  one-cycle transfer acknowledge.
REQ-014 wbs_dat_o  output  32  read data, valid only while wbs_ack_o=1.
REQ-015 busy_o  output  1  high while a transfer is pending (WAIT or ACK state).

Function
REQ-016 hit SHALL equal ((wbs_adr_i & ADDR_MASK) == ADDR_BASE); word index = wbs_adr_i[AW+1:2]; wbs_adr_i[1:0] ignored; aliases above AW+1 wrap into storage.
REQ-017 FSM states SHALL be IDLE, WAIT, ACK.
REQ-018 IDLE: edge sampling cyc=stb=hit=1 ("edge 0") SHALL latch we, sel, index, write data, clear the wait counter, and go to WAIT.
REQ-019 IDLE: cyc=1, stb=1, hit=0 SHALL be ignored (no ack, no state change, storage untouched).
REQ-020 WAIT: counter SHALL increment by 1 per edge; on edge DELAYS (counter reaching DELAYS-1 beforehand) FSM SHALL enter ACK.
REQ-021 On the WAIT->ACK edge a write SHALL update only bytes with latched sel bit 1; a read SHALL register storage[index] into wbs_dat_o.
REQ-022 ACK: wbs_ack_o=1 for exactly one cycle; next edge SHALL return to IDLE, deassert ack and clear wbs_dat_o to 0.
REQ-023 Bus inputs changing during WAIT/ACK SHALL have no effect; only latched values are used.
REQ-024 cyc=0 sampled in WAIT (abort) SHALL return to IDLE with no ack and no storage write.
REQ-025 A new request SHALL be accepted no earlier than the first edge in IDLE after ACK; back-to-back transfers are therefore DELAYS+2 cycles apart minimum.
REQ-026 wbs_dat_o SHALL be 0 whenever wbs_ack_o=0; for writes it SHALL be 0 also during ack.
REQ-027 Counter width SHALL be 8 bits; it never wraps since DELAYS<=255.
REQ-028 busy_o SHALL be 1 in WAIT and ACK, 0 in IDLE.

Reset
REQ-029 wb_rst_n=0 SHALL immediately force IDLE, counter=0, wbs_ack_o=0, wbs_dat_o=0, busy_o=0, independent of the clock.
REQ-030 Reset during WAIT or ACK SHALL cancel the transfer; a pending write SHALL not be committed.
REQ-031 Storage contents SHALL NOT be reset; reads of unwritten words return undefined data.
REQ-032 First request SHALL be accepted on the first edge with wb_rst_n=1.

Verification
REQ-033 Write 0x3800_0010 data 0xDEADBEEF sel 4'hF, DELAYS=10 -> ack high after edge 10 for one cycle, busy_o high edges 0..11; read same address -> wbs_dat_o=0xDEADBEEF with ack.
REQ-034 Word 0x3800_0020 holds 0x11223344; write 0xAABBCCDD sel 4'b0101 -> read returns 0x11BB33DD.
REQ-035 Request to 0x3000_0000 held 50 cycles -> no ack, busy_o stays 0, storage unchanged.
REQ-036 Write started, cyc dropped at edge 5 -> no ack, FSM IDLE at edge 6, later read returns old value.
REQ-037 wb_rst_n pulsed low at edge 4 of a write -> ack, busy_o, wbs_dat_o 0 asynchronously; write not committed; next request after release completes normally.
REQ-038 Two back-to-back reads with stb held, DELAYS=1 -> acks after edges 1 and 4, each one cycle wide, correct data each.
